// File: rtl/mismatch_monitor.sv
// mismatch_monitor: compares CH channels of W-bit DUT outputs against reference
// values over a window of WINDOW compared cycles and gathers statistics.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           run/continue comparison; low pauses the run
//   clear            synchronous clear of all statistics and state (beats enable)
//   y_dut, y_ref     CH*W packed channel values, channel c at [c*W +: W]
//   mismatch         per-channel flag, registered one cycle after a compared cycle
//   fail             sticky: some channel mismatched during this run
//   err_count        compared cycles with any mismatch, saturating
//   first_err_cycle  compared-cycle index of the first mismatch
//   first_err_mask   channels mismatching on that first cycle
//   done             high while the run window is complete

// Per-channel comparator. Written as an if/else so that an X/Z on an input
// makes the condition unknown, which falls into the "differs" branch in
// simulation while still synthesizing to a plain XOR-reduce.
module mismatch_monitor_lane #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         mm_o
);
  always_comb begin
    if ((a_i ^ b_i) == '0) mm_o = 1'b0;
    else                   mm_o = 1'b1;
  end
endmodule

module mismatch_monitor #(
  parameter int W      = 1,
  parameter int CH     = 1,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CH*W-1:0]   y_dut,
  input  logic [CH*W-1:0]   y_ref,
  output logic [CH-1:0]     mismatch,
  output logic              fail,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_cycle,
  output logic [CH-1:0]     first_err_mask,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CH-1:0]     mm_q, fmask_q;
  logic              fail_q, done_q;
  logic [CNT_W-1:0]  err_q, err_d, fcyc_q;

  logic [CH-1:0]     mm_vec;
  logic              cmp, any_mm;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    mismatch_monitor_lane #(.W(W)) u_lane (
      .a_i  (y_dut[c*W +: W]),
      .b_i  (y_ref[c*W +: W]),
      .mm_o (mm_vec[c])
    );
  end

  // IDLE with enable is compared cycle 0; nothing is compared once DONE.
  assign cmp    = enable && (state_q != DONE);
  assign any_mm = |mm_vec;
  assign err_d  = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      mm_q    <= '0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      fcyc_q  <= '0;
      fmask_q <= '0;
      done_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      mm_q    <= '0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      fcyc_q  <= '0;
      fmask_q <= '0;
      done_q  <= 1'b0;
    end else begin
      mm_q <= '0;
      if (cmp) begin
        mm_q  <= mm_vec;
        cyc_q <= cyc_q + 1'b1;
        if (any_mm) begin
          err_q <= err_d;
          if (!fail_q) begin
            fail_q  <= 1'b1;
            fcyc_q  <= cyc_q;
            fmask_q <= mm_vec;
          end
        end
        // With WINDOW=1 this takes IDLE straight to DONE.
        if (cyc_q == WIN_LAST) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end
    end
  end

  assign mismatch        = mm_q;
  assign fail            = fail_q;
  assign err_count       = err_q;
  assign first_err_cycle = fcyc_q;
  assign first_err_mask  = fmask_q;
  assign done            = done_q;
endmodule

// File: tb/tb_mismatch_monitor.sv
module tb_mismatch_monitor;
  logic       clk = 1'b0;
  logic       rst_n, enable, clear;
  logic [7:0] y_dut, y_ref;

  logic [1:0]  a_mm, a_fm, b_mm, b_fm;
  logic        a_fail, a_done, b_fail, b_done;
  logic [15:0] a_err, a_fc;
  logic [3:0]  b_err, b_fc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mismatch_monitor #(.W(4), .CH(2), .CNT_W(16), .WINDOW(40)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .y_dut(y_dut), .y_ref(y_ref), .mismatch(a_mm), .fail(a_fail),
    .err_count(a_err), .first_err_cycle(a_fc), .first_err_mask(a_fm), .done(a_done));

  mismatch_monitor #(.W(4), .CH(2), .CNT_W(4), .WINDOW(15)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .y_dut(y_dut), .y_ref(y_ref), .mismatch(b_mm), .fail(b_fail),
    .err_count(b_err), .first_err_cycle(b_fc), .first_err_mask(b_fm), .done(b_done));

  // Reference model: the run is a count of compared cycles; statistics are
  // derived directly from the per-cycle channel comparison.
  typedef struct {
    bit running, finished, fail;
    int idx, errs, fcyc, fmask, mm;
  } mdl_t;
  typedef struct { mdl_t a; mdl_t b; } exp_t;

  mdl_t ma, mb, zero_m;
  exp_t q[$];

  function automatic mdl_t step(mdl_t m, int win, int cmax, bit clr, bit en,
                                logic [7:0] d, logic [7:0] r);
    mdl_t n;
    int v;
    n = m;
    if (clr) return zero_m;
    n.mm = 0;
    if (en && !m.finished) begin
      v = 0;
      for (int c = 0; c < 2; c++)
        if (d[c*4 +: 4] !== r[c*4 +: 4]) v = v | (1 << c);
      n.mm = v;
      if (v != 0) begin
        n.errs = (m.errs + 1 > cmax) ? cmax : m.errs + 1;
        if (!m.fail) begin
          n.fail = 1; n.fcyc = m.idx; n.fmask = v;
        end
      end
      n.idx      = m.idx + 1;
      n.running  = 1;
      n.finished = (n.idx == win);
    end
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_a_mm"}, a_mm, 0);     chk({tag, "_a_fail"}, a_fail, 0);
    chk({tag, "_a_err"}, a_err, 0);   chk({tag, "_a_fc"}, a_fc, 0);
    chk({tag, "_a_fm"}, a_fm, 0);     chk({tag, "_a_done"}, a_done, 0);
    chk({tag, "_b_err"}, b_err, 0);   chk({tag, "_b_fail"}, b_fail, 0);
    chk({tag, "_b_done"}, b_done, 0);
  endtask

  // One clock of stimulus, applied at the falling edge; expectation for the
  // next rising edge goes into the scoreboard queue.
  task automatic drive(bit clr, bit en, logic [7:0] d, logic [7:0] r, bit rst);
    @(negedge clk);
    clear = clr; enable = en; y_dut = d; y_ref = r;
    if (rst) begin
      #1 rst_n = 1'b0;
      #1 chk_zero("async_rst");
      #1 rst_n = 1'b1;
      ma = zero_m; mb = zero_m;
    end
    ma = step(ma, 40, 65535, clr, en, d, r);
    mb = step(mb, 15, 15, clr, en, d, r);
    q.push_back('{ma, mb});
  endtask

  // Monitor: every rising edge the DUTs present new registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a_mismatch", a_mm, e.a.mm);     chk("a_fail", a_fail, e.a.fail);
        chk("a_err", a_err, e.a.errs);       chk("a_first_cyc", a_fc, e.a.fcyc);
        chk("a_first_mask", a_fm, e.a.fmask); chk("a_done", a_done, e.a.finished);
        chk("b_mismatch", b_mm, e.b.mm);     chk("b_fail", b_fail, e.b.fail);
        chk("b_err", b_err, e.b.errs);       chk("b_first_cyc", b_fc, e.b.fcyc);
        chk("b_first_mask", b_fm, e.b.fmask); chk("b_done", b_done, e.b.finished);
      end
    end
  end

  initial begin
    logic [7:0] d, r;
    int mode;
    zero_m = '{default: 0};
    ma = zero_m; mb = zero_m;
    rst_n = 1'b1; enable = 1'b0; clear = 1'b0; y_dut = '0; y_ref = '0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    #9 rst_n = 1'b1;

    // All matching for 45 cycles: both windows complete cleanly.
    for (int i = 0; i < 45; i++) drive(0, 1, 8'h37, 8'h37, 0);
    @(negedge clk);
    chk("all_match_done", a_done, 1); chk("all_match_fail", a_fail, 0);
    chk("all_match_err", a_err, 0);
    drive(1, 0, 8'h00, 8'h00, 0);

    // Channel 1 mismatching on compared cycles 3 and 9 only.
    for (int i = 0; i < 45; i++)
      drive(0, 1, (i == 3 || i == 9) ? 8'h57 : 8'h77, 8'h77, 0);
    @(negedge clk);
    chk("ch1_err", a_err, 2); chk("ch1_first_cyc", a_fc, 3);
    chk("ch1_first_mask", a_fm, 2); chk("ch1_fail", a_fail, 1);
    drive(1, 0, 8'h00, 8'h00, 0);

    // Both channels mismatching on cycle 0 count as a single error cycle.
    for (int i = 0; i < 45; i++) drive(0, 1, (i == 0) ? 8'h00 : 8'hA5, 8'hA5, 0);
    @(negedge clk);
    chk("both_err", a_err, 1); chk("both_mask", a_fm, 3); chk("both_cyc", a_fc, 0);
    drive(1, 0, 8'h00, 8'h00, 0);

    // Pause for 5 cycles with mismatching data that must not be counted.
    for (int i = 0; i < 10; i++) drive(0, 1, 8'h11, 8'h11, 0);
    for (int i = 0; i < 5; i++)  drive(0, 0, 8'hFF, 8'h00, 0);
    for (int i = 0; i < 32; i++) drive(0, 1, 8'h11, 8'h11, 0);
    drive(1, 0, 8'h00, 8'h00, 0);

    // Every cycle mismatching: narrow counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      drive(0, 1, ~r, r, 0);
    end
    @(negedge clk);
    chk("sat_b_err", b_err, 15); chk("sat_b_done", b_done, 1);
    chk("sat_a_err", a_err, 20);

    // Async reset mid-run, then a fresh run to DONE, then clear with enable.
    drive(1, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'h0F, 8'h1F, 0);
    drive(0, 1, 8'h22, 8'h22, 1);
    for (int i = 0; i < 45; i++) drive(0, 1, 8'h0F, (i == 7) ? 8'h0E : 8'h0F, 0);
    drive(1, 1, 8'hFF, 8'h00, 0);
    drive(0, 0, 8'h00, 8'h00, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r = 8'($urandom);
      d = r;
      mode = $urandom_range(0, 9);
      if (mode >= 6 && mode <= 8) d = r ^ 8'($urandom_range(1, 255));
      if (mode == 9) d[3:0] = 4'bx1z0;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 85, d, r,
            $urandom_range(0, 99) == 0);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
